// File: rtl/imem_responder.sv
// Instruction-memory responder for the Simple_core fetch port: registered one-cycle reads,
// plus a valid/ready word loader that fills the program store while holding the core off.
module imem_responder #(
    parameter int          DEPTH_LOG2 = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           to_imem,
    output logic [31:0]           fr_imem,
    output logic                  imem_fault,
    input  logic                  ld_start,
    input  logic [DEPTH_LOG2:0]   ld_count,
    input  logic                  ld_valid,
    input  logic [31:0]           ld_data,
    output logic                  ld_ready,
    output logic                  ld_done,
    output logic                  core_hold
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]     left_q, left_d;
    logic [31:0]             fr_imem_q, fr_imem_d;
    logic                    fault_q, fault_d;
    logic [31:0]             mem_q [DEPTH];

    logic [31:0]             off;
    logic [DEPTH_LOG2-1:0]   rd_idx;
    logic                    fetch_ok;
    logic                    mem_we;

    assign off      = to_imem - BASE_ADDR;
    assign rd_idx   = off[DEPTH_LOG2+1:2];
    assign fetch_ok = (off[1:0] == 2'b00) && (off[31:DEPTH_LOG2+2] == '0);

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        left_d    = left_q;
        fr_imem_d = NOP_WORD;
        fault_d   = 1'b0;
        mem_we    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (fetch_ok) begin
                    fr_imem_d = mem_q[rd_idx];
                end else begin
                    fault_d = 1'b1;
                end
                if (ld_start && (ld_count != '0)) begin
                    state_d  = S_LOAD;
                    wr_ptr_d = '0;
                    // Oversized counts are clamped so the pointer never wraps onto word 0.
                    left_d   = (ld_count > DEPTH_CNT) ? DEPTH_CNT : ld_count;
                end
            end
            S_LOAD: begin
                if (ld_valid) begin
                    mem_we   = rst;
                    wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
                    left_d   = left_q - (DEPTH_LOG2+1)'(1);
                    if (left_q == (DEPTH_LOG2+1)'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            fr_imem_q <= NOP_WORD;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            fr_imem_q <= fr_imem_d;
            fault_q   <= fault_d;
        end
    end

    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        left_q   <= left_d;
    end

    // Program store is never cleared by reset; a reset mid-load keeps words already taken.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= ld_data;
        end
    end

    assign fr_imem    = fr_imem_q;
    assign imem_fault = fault_q;
    assign ld_ready   = (state_q == S_LOAD);
    assign ld_done    = (state_q == S_DONE);
    assign core_hold  = (state_q != S_IDLE);

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: randomized loads and fetches against an array model.
module tb_imem_responder;

    localparam int          DL    = 8;
    localparam int          DEPTH = 1 << DL;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   to_imem = '0;
    logic [31:0]   fr_imem;
    logic          imem_fault;
    logic          ld_start = 1'b0;
    logic [DL:0]   ld_count = '0;
    logic          ld_valid = 1'b0;
    logic [31:0]   ld_data = '0;
    logic          ld_ready;
    logic          ld_done;
    logic          core_hold;

    always #5 clk = ~clk;

    imem_responder #(
        .DEPTH_LOG2(DL),
        .BASE_ADDR (32'h0000_0000),
        .NOP_WORD  (NOP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .to_imem   (to_imem),
        .fr_imem   (fr_imem),
        .imem_fault(imem_fault),
        .ld_start  (ld_start),
        .ld_count  (ld_count),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .ld_done   (ld_done),
        .core_hold (core_hold)
    );

    logic [31:0] model [DEPTH];
    logic [31:0] src_q [$];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic void exp_fetch(input logic [31:0] a, output logic [31:0] w, output logic f);
        logic [31:0] off;
        off = a - 32'h0000_0000;
        if ((off % 4 == 0) && (off < 4 * DEPTH)) begin
            w = model[int'(off / 4)];
            f = 1'b0;
        end else begin
            w = NOP;
            f = 1'b1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one load transaction and reports what it observed; the tests judge the results.
    task automatic run_load(input int cnt, input int gap_at, input int gap_len, input bit rnd_gap,
                            input bit toggle, output int acc, output int bad_hs,
                            output int bad_fetch, output bit done_ok, output bit after_ok);
        int n_exp, cyc, gapc;
        bit v;
        logic [31:0] d;
        n_exp = (cnt > DEPTH) ? DEPTH : cnt;
        acc = 0; bad_hs = 0; bad_fetch = 0; cyc = 0; gapc = 0;
        ld_count = (DL+1)'(cnt);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        while (acc < n_exp && cyc < 2000) begin
            if (ld_ready !== 1'b1 || core_hold !== 1'b1 || ld_done !== 1'b0) bad_hs++;
            if (cyc > 0 && (fr_imem !== NOP || imem_fault !== 1'b0)) bad_fetch++;
            if (toggle) to_imem = cyc[0] ? 32'd4 : 32'd0;
            if (rnd_gap) begin
                v = ($urandom_range(0, 2) != 0);
            end else begin
                v = !(acc == gap_at && gapc < gap_len);
                if (!v) gapc++;
            end
            d = $urandom;
            if (v && src_q.size() > 0) d = src_q.pop_front();
            ld_valid = v;
            ld_data  = d;
            tick();
            if (v) begin
                model[acc] = d;
                acc++;
            end
            cyc++;
        end
        ld_valid = 1'b0;
        done_ok = (ld_done === 1'b1) && (ld_ready === 1'b0) && (core_hold === 1'b1)
               && (fr_imem === NOP) && (imem_fault === 1'b0);
        tick();
        after_ok = (ld_done === 1'b0) && (ld_ready === 1'b0) && (core_hold === 1'b0)
                && (fr_imem === NOP) && (imem_fault === 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        to_imem = 32'd0;
        repeat (3) tick();
        n_tests++;
        if (fr_imem !== NOP || imem_fault !== 1'b0 || ld_ready !== 1'b0 || ld_done !== 1'b0
            || core_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: fr_imem=%h fault=%b ready=%b done=%b hold=%b, expected %h 0 0 0 0",
                     fr_imem, imem_fault, ld_ready, ld_done, core_hold, NOP);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_count_edges();
        int acc, bad_hs, bad_fetch;
        bit done_ok, after_ok;
        logic [31:0] ew;
        logic ef;
        int idx;
        ld_count = '0;
        ld_start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            ld_start = 1'b0;
            n_tests++;
            if (ld_ready !== 1'b0 || core_hold !== 1'b0) begin
                n_fail++;
                $display("FAIL count_zero cyc%0d: ready=%b hold=%b, expected 0 0", i, ld_ready, core_hold);
            end
        end
        run_load(300, 0, 0, 1'b1, 1'b0, acc, bad_hs, bad_fetch, done_ok, after_ok);
        n_tests++;
        if (acc !== DEPTH || bad_hs !== 0 || done_ok !== 1'b1 || after_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL count_clamp: accepted=%0d bad_hs=%0d done=%b after=%b, expected %0d 0 1 1",
                     acc, bad_hs, done_ok, after_ok, DEPTH);
        end
        for (int i = 0; i < 10; i++) begin
            idx = (i == 0) ? 0 : (i == 1) ? DEPTH - 1 : $urandom_range(0, DEPTH - 1);
            exp_fetch(32'(idx * 4), ew, ef);
            to_imem = 32'(idx * 4);
            tick();
            n_tests++;
            if (fr_imem !== ew || imem_fault !== ef) begin
                n_fail++;
                $display("FAIL full_load_fetch idx=%0d: got %h/%b, expected %h/%b",
                         idx, fr_imem, imem_fault, ew, ef);
            end
        end
    endtask

    task automatic test_load_fetch();
        int acc, bad_hs, bad_fetch;
        bit done_ok, after_ok;
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h0031_0463; exp_w[1] = 32'h0031_4463; exp_w[2] = 32'h0011_C133;
        src_q = {exp_w[0], exp_w[1], exp_w[2]};
        to_imem = 32'd0;
        run_load(3, 1, 2, 1'b0, 1'b0, acc, bad_hs, bad_fetch, done_ok, after_ok);
        n_tests++;
        if (acc !== 3 || bad_hs !== 0 || bad_fetch !== 0 || done_ok !== 1'b1 || after_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL load3: accepted=%0d bad_hs=%0d bad_fetch=%0d done=%b after=%b, expected 3 0 0 1 1",
                     acc, bad_hs, bad_fetch, done_ok, after_ok);
        end
        for (int i = 0; i < 3; i++) begin
            to_imem = 32'(i * 4);
            tick();
            n_tests++;
            if (fr_imem !== exp_w[i] || imem_fault !== 1'b0) begin
                n_fail++;
                $display("FAIL load3_fetch addr=%0d: got %h/%b, expected %h/0", i * 4, fr_imem, imem_fault, exp_w[i]);
            end
        end
    endtask

    task automatic test_faults();
        logic [31:0] addrs [3];
        logic [31:0] ew;
        logic ef;
        addrs[0] = 32'h2; addrs[1] = 32'(4 * DEPTH); addrs[2] = 32'(4 * (DEPTH - 1));
        for (int i = 0; i < 3; i++) begin
            exp_fetch(addrs[i], ew, ef);
            to_imem = addrs[i];
            tick();
            n_tests++;
            if (fr_imem !== ew || imem_fault !== ef) begin
                n_fail++;
                $display("FAIL fault addr=%h: got %h/%b, expected %h/%b", addrs[i], fr_imem, imem_fault, ew, ef);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] w [2];
        w[0] = $urandom; w[1] = $urandom;
        to_imem = 32'd0;
        ld_count = (DL+1)'(4);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (ld_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL midload_ready word%0d: ready=%b, expected 1", i, ld_ready);
            end
            ld_valid = 1'b1;
            ld_data  = w[i];
            tick();
            model[i] = w[i];
        end
        ld_valid = 1'b0;
        rst = 1'b0;
        tick();
        n_tests++;
        if (ld_ready !== 1'b0 || core_hold !== 1'b0 || ld_done !== 1'b0 || fr_imem !== NOP) begin
            n_fail++;
            $display("FAIL midload_reset: ready=%b hold=%b done=%b fr=%h, expected 0 0 0 %h",
                     ld_ready, core_hold, ld_done, fr_imem, NOP);
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            to_imem = 32'(i * 4);
            tick();
            n_tests++;
            if (ld_done !== 1'b0 || core_hold !== 1'b0) begin
                n_fail++;
                $display("FAIL midload_nodone cyc%0d: done=%b hold=%b, expected 0 0", i, ld_done, core_hold);
            end
        end
        for (int i = 0; i < 4; i++) begin
            to_imem = 32'(i * 4);
            tick();
            n_tests++;
            if (fr_imem !== model[i] || imem_fault !== 1'b0) begin
                n_fail++;
                $display("FAIL midload_mem word%0d: got %h/%b, expected %h/0", i, fr_imem, imem_fault, model[i]);
            end
        end
    endtask

    task automatic test_fetch_during_load();
        int acc, bad_hs, bad_fetch;
        bit done_ok, after_ok;
        to_imem = 32'd0;
        run_load(5, 0, 0, 1'b1, 1'b1, acc, bad_hs, bad_fetch, done_ok, after_ok);
        n_tests++;
        if (acc !== 5 || bad_hs !== 0 || bad_fetch !== 0 || done_ok !== 1'b1 || after_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_in_load: accepted=%0d bad_hs=%0d bad_fetch=%0d done=%b after=%b, expected 5 0 0 1 1",
                     acc, bad_hs, bad_fetch, done_ok, after_ok);
        end
    endtask

    task automatic test_random_fetch();
        logic [31:0] a, ew;
        logic ef;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 2))
                0:       a = 32'($urandom_range(0, DEPTH - 1) * 4);
                1:       a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
                default: a = $urandom;
            endcase
            exp_fetch(a, ew, ef);
            to_imem = a;
            tick();
            n_tests++;
            if (fr_imem !== ew || imem_fault !== ef) begin
                n_fail++;
                $display("FAIL rand_fetch addr=%h: got %h/%b, expected %h/%b", a, fr_imem, imem_fault, ew, ef);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_edges();
        test_load_fetch();
        test_faults();
        test_reset_mid_load();
        test_fetch_during_load();
        test_random_fetch();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
